muxn_seq: RTL and testbench

//   Parametrised N-channel, WIDTH-bit registered multiplexer with a valid/ready output stage.

---
 rtl/muxn_seq_if.sv | 32 +++
 rtl/muxn_seq.sv | 97 +++++++++
 tb/tb_muxn_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/muxn_seq_if.sv
// muxn_seq_if: data, handshake and status bundle for the muxn_seq N-channel registered mux.
// The optional f_par signal exists only when MUXN_SEQ_PARITY_EN is defined.
interface muxn_seq_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NCH   = 2
);
    localparam int unsigned SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH*WIDTH-1:0] d;
    logic                 en;
    logic                 mode;
    logic [SW-1:0]        sel;
    logic                 sel_ld;
    logic [WIDTH-1:0]     f;
    logic [SW-1:0]        ch;
    logic                 f_vld;
    logic                 f_rdy;
    logic                 err;
`ifdef MUXN_SEQ_PARITY_EN
    logic                 f_par;

    modport master (output d, en, mode, sel, sel_ld, f_rdy,
                    input  f, ch, f_vld, err, f_par);
    modport slave  (input  d, en, mode, sel, sel_ld, f_rdy,
                    output f, ch, f_vld, err, f_par);
`else
    modport master (output d, en, mode, sel, sel_ld, f_rdy,
                    input  f, ch, f_vld, err);
    modport slave  (input  d, en, mode, sel, sel_ld, f_rdy,
                    output f, ch, f_vld, err);
`endif
endinterface

// File: rtl/muxn_seq.sv
// muxn_seq: NCH-channel, WIDTH-bit registered mux with a channel pointer, round-robin
// auto-scan and a valid/ready output stage.
// Optional feature: define MUXN_SEQ_PARITY_EN to add f_par (even parity of the captured word).
module muxn_seq #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NCH   = 2
) (
    input  logic      clk,
    input  logic      rst,
    muxn_seq_if.slave bus
);
    localparam int unsigned SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [WIDTH-1:0] f_q;
    logic [WIDTH-1:0] word_c;
    logic [SW-1:0]    ch_q;
    logic [SW-1:0]    ptr;
    logic [SW-1:0]    ptr_nxt_c;
    logic             f_vld_q;
    logic             err_q;
    logic             cap_c;
    logic             sel_ok_c;
    logic             sel_bad_c;

    // Capture when enabled and the output slot is empty or being drained this cycle
    assign cap_c     = bus.en & (~f_vld_q | bus.f_rdy);
    assign sel_ok_c  = bus.sel_ld & (32'(bus.sel) < NCH);
    assign sel_bad_c = bus.sel_ld & ~(32'(bus.sel) < NCH);

    // Channel selection by the current pointer
    always_comb begin
        word_c = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (ptr == SW'(k)) begin
                word_c = bus.d[k*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer next state: valid load beats scan step; a bad load freezes the pointer
    always_comb begin
        ptr_nxt_c = ptr;
        if (sel_ok_c) begin
            ptr_nxt_c = bus.sel;
        end else if (sel_bad_c) begin
            ptr_nxt_c = ptr;
        end else if (bus.mode && cap_c) begin
            ptr_nxt_c = (ptr == SW'(NCH - 1)) ? '0 : ptr + SW'(1);
        end
    end

    // Pointer and error-pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            err_q <= 1'b0;
        end else begin
            ptr   <= ptr_nxt_c;
            err_q <= sel_bad_c;
        end
    end

    // Output stage: capture, drain, or hold under stall
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q     <= '0;
            ch_q    <= '0;
            f_vld_q <= 1'b0;
        end else if (cap_c) begin
            f_q     <= word_c;
            ch_q    <= ptr;
            f_vld_q <= 1'b1;
        end else if (~bus.en & bus.f_rdy) begin
            f_vld_q <= 1'b0;
        end
    end

`ifdef MUXN_SEQ_PARITY_EN
    logic par_q;

    // Parity travels with the captured word
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (cap_c) begin
            par_q <= ^word_c;
        end
    end

    assign bus.f_par = par_q;
`endif

    assign bus.f     = f_q;
    assign bus.ch    = ch_q;
    assign bus.f_vld = f_vld_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_muxn_seq.sv
// tb_muxn_seq: directed checks of muxn_seq with a 4-channel and a 3-channel instance.
module tb_muxn_seq;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muxn_seq_if #(.WIDTH(4), .NCH(4)) a ();
    muxn_seq_if #(.WIDTH(4), .NCH(3)) b ();

    muxn_seq #(.WIDTH(4), .NCH(4)) u_a (.clk(clk), .rst(rst), .bus(a));
    muxn_seq #(.WIDTH(4), .NCH(3)) u_b (.clk(clk), .rst(rst), .bus(b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] ef, input logic [1:0] ec,
                         input logic ev, input logic ee);
        chk({tag, ".f"}, 32'(a.f), 32'(ef));
        chk({tag, ".ch"}, 32'(a.ch), 32'(ec));
        chk({tag, ".vld"}, 32'(a.f_vld), 32'(ev));
        chk({tag, ".err"}, 32'(a.err), 32'(ee));
`ifdef MUXN_SEQ_PARITY_EN
        chk({tag, ".par"}, 32'(a.f_par), 32'(^ef));
`endif
    endtask

    task automatic chk_b(input string tag, input logic [3:0] ef, input logic [1:0] ec,
                         input logic ev, input logic ee);
        chk({tag, ".f"}, 32'(b.f), 32'(ef));
        chk({tag, ".ch"}, 32'(b.ch), 32'(ec));
        chk({tag, ".vld"}, 32'(b.f_vld), 32'(ev));
        chk({tag, ".err"}, 32'(b.err), 32'(ee));
`ifdef MUXN_SEQ_PARITY_EN
        chk({tag, ".par"}, 32'(b.f_par), 32'(^ef));
`endif
    endtask

    initial begin
        logic [3:0] scan_f [5];
        scan_f[0] = 4'hA; scan_f[1] = 4'hB; scan_f[2] = 4'hC; scan_f[3] = 4'hD; scan_f[4] = 4'hA;

        // Reset with random activity on the 4-channel unit, idle 3-channel unit
        rst      = 1'b1;
        a.d      = 16'($urandom);
        a.en     = 1'b1;
        a.mode   = 1'($urandom);
        a.sel    = 2'($urandom);
        a.sel_ld = 1'b1;
        a.f_rdy  = 1'($urandom);
        b.d      = 12'h000;
        b.en     = 1'b0;
        b.mode   = 1'b0;
        b.sel    = 2'd3;
        b.sel_ld = 1'b1;
        b.f_rdy  = 1'b0;
        tick();
        chk_a("rst1_a", 4'h0, 2'd0, 1'b0, 1'b0);
        chk_b("rst1_b", 4'h0, 2'd0, 1'b0, 1'b0);
        a.d = 16'($urandom);
        tick();
        chk_a("rst2_a", 4'h0, 2'd0, 1'b0, 1'b0);
        rst      = 1'b0;
        b.sel_ld = 1'b0;

        // Manual select: current capture uses old ptr, following words come from ch 2
        a.d      = 16'hDCBA;
        a.mode   = 1'b0;
        a.en     = 1'b1;
        a.f_rdy  = 1'b1;
        a.sel_ld = 1'b1;
        a.sel    = 2'd2;
        tick();
        chk_a("man_old", 4'hA, 2'd0, 1'b1, 1'b0);
        a.sel_ld = 1'b0;
        tick();
        chk_a("man_new", 4'hC, 2'd2, 1'b1, 1'b0);
        tick();
        chk_a("man_hold", 4'hC, 2'd2, 1'b1, 1'b0);

        // Scan with a load at ptr=2: load beats increment
        a.mode   = 1'b1;
        a.sel_ld = 1'b1;
        a.sel    = 2'd0;
        tick();
        chk_a("ld_vs_inc", 4'hC, 2'd2, 1'b1, 1'b0);
        a.sel_ld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_a($sformatf("scan%0d", i), scan_f[i], 2'(i % 4), 1'b1, 1'b0);
        end
        tick();
        chk_a("scan_b", 4'hB, 2'd1, 1'b1, 1'b0);

        // Stall while f=B with d changing
        a.f_rdy = 1'b0;
        a.d     = 16'h1111;
        tick();
        chk_a("stall0", 4'hB, 2'd1, 1'b1, 1'b0);
        a.d = 16'h2222;
        tick();
        chk_a("stall1", 4'hB, 2'd1, 1'b1, 1'b0);
        a.d = 16'h4321;
        tick();
        chk_a("stall2", 4'hB, 2'd1, 1'b1, 1'b0);
        a.f_rdy = 1'b1;
        tick();
        chk_a("unstall", 4'h3, 2'd2, 1'b1, 1'b0);
        a.en = 1'b0;
        tick();
        chk_a("drain", 4'h3, 2'd2, 1'b0, 1'b0);

        // Three channels: scan wraps 2 -> 0
        b.d     = 12'h987;
        b.mode  = 1'b1;
        b.en    = 1'b1;
        b.f_rdy = 1'b1;
        tick();
        chk_b("w0", 4'h7, 2'd0, 1'b1, 1'b0);
        tick();
        chk_b("w1", 4'h8, 2'd1, 1'b1, 1'b0);
        tick();
        chk_b("w2", 4'h9, 2'd2, 1'b1, 1'b0);
        tick();
        chk_b("wrap", 4'h7, 2'd0, 1'b1, 1'b0);
        tick();
        chk_b("w4", 4'h8, 2'd1, 1'b1, 1'b0);

        // Out-of-range load during a stall: one-cycle err, sequence continues
        b.f_rdy  = 1'b0;
        b.sel_ld = 1'b1;
        b.sel    = 2'd3;
        tick();
        chk_b("bad_sel", 4'h8, 2'd1, 1'b1, 1'b1);
        b.sel_ld = 1'b0;
        b.f_rdy  = 1'b1;
        tick();
        chk_b("err_clr", 4'h9, 2'd2, 1'b1, 1'b0);
        tick();
        chk_b("w7", 4'h7, 2'd0, 1'b1, 1'b0);
        tick();
        chk_b("w8", 4'h8, 2'd1, 1'b1, 1'b0);

        // Load sel=0 together with a capture at ptr=2
        b.sel_ld = 1'b1;
        b.sel    = 2'd0;
        tick();
        chk_b("ld_cap", 4'h9, 2'd2, 1'b1, 1'b0);
        b.sel_ld = 1'b0;
        tick();
        chk_b("ld_next", 4'h7, 2'd0, 1'b1, 1'b0);

        // Reset in the middle of a stall discards the word and the pointer
        b.f_rdy = 1'b0;
        tick();
        chk_b("pre_rst", 4'h7, 2'd0, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        chk_b("mid_rst", 4'h0, 2'd0, 1'b0, 1'b0);
        rst     = 1'b0;
        b.mode  = 1'b0;
        b.f_rdy = 1'b1;
        tick();
        chk_b("post_rst", 4'h7, 2'd0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
